fetch_controller: RTL and testbench

- Sequences the instruction prefetch buffer: issues word fetches to instruction memory, steers returned words into the buffer, and pops 16- or 32-bit instructions toward decode.
- Tracks the fetch PC and handles control-flow redirects, including misaligned (pc[1]=1) targets.
- Discards responses still in flight when a redirect occurs.
- Sits between the imem port, the 4-entry halfword-addressed prefetch buffer, and the decode stage.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_outstanding_tracker.sv | 46 ++++
 rtl/fetch_controller.sv | 154 +++++++++++++++
 tb/tb_fetch_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and encodings for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ALIGN = 2'd2
  } fetch_state_e;

  // Prefetch buffer read-enable encodings
  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_HALF = 2'b10;
  localparam logic [1:0] RD_WORD = 2'b11;

  // Low two bits of a halfword that starts a 32-bit instruction
  localparam logic [1:0] ILEN32_LSBS = 2'b11;

endpackage

// File: rtl/fetch_outstanding_tracker.sv
// Counts granted-but-unreturned imem requests and how many of them are stale
// (issued before the last redirect) so their responses can be dropped.
module fetch_outstanding_tracker #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gnt,
  input  logic             rvalid,
  input  logic             flush,
  output logic [CNT_W-1:0] outstanding,
  output logic             drop_resp
);

  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] out_next;
  logic             resp_live;

  // A response only counts when a request is actually in flight; anything
  // arriving with nothing outstanding is a leftover from before reset.
  always_comb begin
    resp_live = rvalid && (outstanding != '0);
    drop_resp = (discard != '0) || (outstanding == '0);
    out_next  = outstanding + CNT_W'(gnt) - CNT_W'(resp_live);
  end

  // Counter update; on a flush every request still in flight (including one
  // granted this cycle) becomes stale, since discard is a subset of outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (flush) begin
        discard <= out_next;
      end else if (resp_live && (discard != '0)) begin
        discard <= discard - CNT_W'(1);
      end
    end
  end

  a_discard_le_outstanding: assert property (@(posedge clk) disable iff (rst)
    discard <= outstanding);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues imem word fetches, steers responses into
// the halfword prefetch buffer and pops 16/32-bit instructions to decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int          BUF_WORDS       = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  output logic        buf_write_en,
  output logic [1:0]  buf_read_en,
  output logic        buf_flush,
  input  logic [1:0]  buf_first_hw_lsbs,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int HW_W  = $clog2(2 * BUF_WORDS + 1) + 1;

  fetch_state_e     state;
  logic [31:0]      pc;
  logic [31:0]      fetch_addr;
  logic [HW_W-1:0]  hw_cnt;
  logic             rd_odd;
  logic [CNT_W-1:0] outstanding;
  logic             drop_resp;

  logic [HW_W-1:0]  slots_used;
  logic [HW_W-1:0]  hw_next;
  logic             active;
  logic             redir;
  logic             compressed;
  logic             grant;
  logic             push;
  logic             pop;
  logic             align_pop;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  fetch_outstanding_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .gnt        (grant),
    .rvalid     (imem_rvalid),
    .flush      (redir),
    .outstanding(outstanding),
    .drop_resp  (drop_resp)
  );

  // Handshake decode; everything is combinational from registered state so a
  // pop presented this cycle is consumed at the next edge with no extra latency.
  always_comb begin
    active     = (state != IDLE) && !rst;
    redir      = active && redirect_valid;
    compressed = (buf_first_hw_lsbs != ILEN32_LSBS);
    // A half-consumed word (rd_odd) still occupies a whole buffer slot.
    slots_used = (hw_cnt + HW_W'(rd_odd) + HW_W'(1)) >> 1;
    imem_req   = active
               && ((int'(slots_used) + int'(outstanding)) < BUF_WORDS)
               && (int'(outstanding) < MAX_OUTSTANDING);
    grant      = imem_req && imem_gnt;
    // Writing into a buffer being flushed would be lost anyway.
    push       = imem_rvalid && !drop_resp && !rst && !redir;
    instr_valid = (state == FETCH) && !rst && !redirect_valid
                && (hw_cnt != '0) && (compressed || (hw_cnt >= HW_W'(2)));
    align_pop  = (state == ALIGN) && !rst && !redirect_valid && (hw_cnt != '0);
    pop        = instr_valid && instr_ready;

    buf_read_en = RD_NONE;
    if (pop) begin
      buf_read_en = compressed ? RD_HALF : RD_WORD;
    end else if (align_pop) begin
      buf_read_en = RD_HALF;
    end

    hw_next = hw_cnt;
    if (push) begin
      hw_next = hw_next + HW_W'(2);
    end
    if (pop) begin
      hw_next = hw_next - (compressed ? HW_W'(1) : HW_W'(2));
    end else if (align_pop) begin
      hw_next = hw_next - HW_W'(1);
    end

    buf_write_en     = push;
    buf_flush        = rst || redir;
    imem_addr        = fetch_addr;
    instr_pc         = pc;
    instr_compressed = compressed && !rst;
  end

  // Fetch FSM with PC, fetch address and buffer occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= BOOT_ADDR;
      fetch_addr <= {BOOT_ADDR[31:2], 2'b00};
      hw_cnt     <= '0;
      rd_odd     <= 1'b0;
    end else if (state == IDLE) begin
      if (redirect_valid) begin
        pc         <= {redirect_pc[31:1], 1'b0};
        fetch_addr <= {redirect_pc[31:2], 2'b00};
      end
      if (fetch_en) begin
        state <= FETCH;
      end
    end else if (redir) begin
      pc         <= {redirect_pc[31:1], 1'b0};
      fetch_addr <= {redirect_pc[31:2], 2'b00};
      hw_cnt     <= '0;
      rd_odd     <= 1'b0;
      state      <= redirect_pc[1] ? ALIGN : FETCH;
    end else begin
      hw_cnt <= hw_next;
      if (grant) begin
        fetch_addr <= fetch_addr + 32'd4;
      end
      if (pop) begin
        pc <= pc + (compressed ? 32'd2 : 32'd4);
        if (compressed) begin
          rd_odd <= ~rd_odd;
        end
      end
      if (align_pop) begin
        // Low halfword of the target word is skipped; we now sit mid-word.
        rd_odd <= ~rd_odd;
        state  <= FETCH;
      end
    end
  end

  a_hw_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    hw_cnt <= HW_W'(2 * BUF_WORDS));
  a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
    !(buf_write_en && (slots_used == HW_W'(BUF_WORDS))));

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small in-order imem model and a
// halfword FIFO standing in for the prefetch buffer.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        rvalid_r = 1'b0;
  logic [31:0] rdata_r = 32'h0;
  logic        buf_write_en;
  logic [1:0]  buf_read_en;
  logic        buf_flush;
  logic [1:0]  first_lsbs = 2'b00;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;
  int cyc      = 0;
  int writes;
  int waitc;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] delay_addr   = 32'hFFFF_FFFF;
  int          delay_cycles = 0;
  logic [31:0] pq_addr [$];
  int          pq_due  [$];
  logic [15:0] hq [$];

  fetch_controller dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en         (fetch_en),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (rvalid_r),
    .buf_write_en     (buf_write_en),
    .buf_read_en      (buf_read_en),
    .buf_flush        (buf_flush),
    .buf_first_hw_lsbs(first_lsbs),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_pc         (instr_pc),
    .instr_compressed (instr_compressed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0013_0013;
  endfunction

  // imem (in-order, 1-cycle latency plus optional per-address delay) and buffer
  always @(posedge clk) begin
    logic [31:0] a;
    logic [15:0] h;
    if (imem_req && imem_gnt) begin
      pq_addr.push_back(imem_addr);
      pq_due.push_back(cyc + 1 + ((imem_addr == delay_addr) ? delay_cycles : 0));
    end
    if (pq_addr.size() > 0 && pq_due[0] <= cyc + 1) begin
      a = pq_addr.pop_front();
      void'(pq_due.pop_front());
      rvalid_r <= 1'b1;
      rdata_r  <= mem_word(a);
    end else begin
      rvalid_r <= 1'b0;
    end
    if (buf_flush) begin
      hq.delete();
    end else begin
      if (buf_read_en == RD_HALF && hq.size() > 0) begin
        void'(hq.pop_front());
      end else if (buf_read_en == RD_WORD && hq.size() > 1) begin
        void'(hq.pop_front());
        void'(hq.pop_front());
      end
      if (buf_write_en) begin
        hq.push_back(rdata_r[15:0]);
        hq.push_back(rdata_r[31:16]);
      end
    end
    if (hq.size() > 0) begin
      h = hq[0];
      first_lsbs <= h[1:0];
    end else begin
      first_lsbs <= 2'b00;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test(input int nrst);
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    repeat (nrst - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0; fetch_en = 1'b1;
    tcyc = 0;
  endtask

  task automatic to_cycle(input int k);
    while (tcyc < k) begin
      @(negedge clk);
      tcyc++;
    end
  endtask

  initial begin
    // ---------------- reset state and boot ----------------
    @(negedge clk); #1;
    check("rst_req", imem_req, 0);
    check("rst_flush", buf_flush, 1);
    check("rst_valid", instr_valid, 0);
    check("rst_wen", buf_write_en, 0);
    check("rst_ren", buf_read_en, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_comp", instr_compressed, 0);
    @(negedge clk);
    rst = 1'b0; fetch_en = 1'b1; tcyc = 0;
    #1 check("boot_idle_req", imem_req, 0);
    for (int k = 1; k <= 4; k++) begin
      to_cycle(k); #1;
      check("boot_req", imem_req, 1);
      check("boot_addr", imem_addr, 32'(4 * (k - 1)));
      if (k == 2) check("boot_valid_c2", instr_valid, 0);
      if (k == 3) begin
        check("boot_valid_c3", instr_valid, 1);
        check("boot_comp", instr_compressed, 0);
        check("boot_pc0", instr_pc, 0);
      end
    end
    to_cycle(5); #1;
    check("boot_req_full", imem_req, 0);
    check("boot_addr_next", imem_addr, 32'h10);
    to_cycle(6); instr_ready = 1'b1; #1;
    check("boot_v6", instr_valid, 1);
    check("boot_pc_a", instr_pc, 32'h0);
    to_cycle(7); #1;
    check("boot_pc_b", instr_pc, 32'h4);
    to_cycle(8); #1;
    check("boot_pc_c", instr_pc, 32'h8);

    // ---------------- compressed mix ----------------
    mem.delete();
    mem[32'h0] = 32'h0001_4501;
    start_test(4);
    instr_ready = 1'b1;
    to_cycle(3); #1;
    check("rvc_v0", instr_valid, 1);
    check("rvc_pc0", instr_pc, 32'h0);
    check("rvc_c0", instr_compressed, 1);
    check("rvc_re0", buf_read_en, 32'(RD_HALF));
    to_cycle(4); #1;
    check("rvc_pc1", instr_pc, 32'h2);
    check("rvc_c1", instr_compressed, 1);
    check("rvc_re1", buf_read_en, 32'(RD_HALF));
    to_cycle(5); #1;
    check("rvc_pc2", instr_pc, 32'h4);
    check("rvc_c2", instr_compressed, 0);
    check("rvc_re2", buf_read_en, 32'(RD_WORD));
    to_cycle(6); #1;
    check("rvc_rd_odd", dut.rd_odd, 0);
    check("rvc_pc3", instr_pc, 32'h8);

    // ---------------- straddling 32-bit instruction ----------------
    mem.delete();
    mem[32'h0] = 32'h0013_4501;
    mem[32'h4] = 32'h4501_0000;
    delay_addr = 32'h4; delay_cycles = 3;
    start_test(4);
    instr_ready = 1'b1;
    to_cycle(3); #1;
    check("str_pc0", instr_pc, 32'h0);
    check("str_c0", instr_compressed, 1);
    for (int k = 4; k <= 6; k++) begin
      to_cycle(k); #1;
      check("str_wait", instr_valid, 0);
    end
    to_cycle(7); #1;
    check("str_valid", instr_valid, 1);
    check("str_pc", instr_pc, 32'h2);
    check("str_comp", instr_compressed, 0);
    check("str_re", buf_read_en, 32'(RD_WORD));

    // ---------------- redirect to misaligned target ----------------
    mem.delete();
    mem[32'h100] = 32'h4501_0000;
    delay_addr = 32'h0; delay_cycles = 3;
    start_test(4);
    to_cycle(3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; #1;
    check("rd_flush", buf_flush, 1);
    check("rd_valid", instr_valid, 0);
    check("rd_re", buf_read_en, 0);
    to_cycle(4);
    redirect_valid = 1'b0; instr_ready = 1'b1; delay_addr = 32'hFFFF_FFFF; #1;
    check("rd_flush_off", buf_flush, 0);
    check("rd_addr", imem_addr, 32'h100);
    check("rd_req_full", imem_req, 0);
    to_cycle(5); #1;
    check("rd_stale0_wen", buf_write_en, 0);
    to_cycle(6); #1;
    check("rd_stale1_wen", buf_write_en, 0);
    check("rd_req", imem_req, 1);
    check("rd_req_addr", imem_addr, 32'h100);
    to_cycle(7); #1;
    check("rd_wen", buf_write_en, 1);
    to_cycle(8); #1;
    check("rd_align_re", buf_read_en, 32'(RD_HALF));
    check("rd_align_valid", instr_valid, 0);
    to_cycle(9); #1;
    check("rd_tgt_valid", instr_valid, 1);
    check("rd_tgt_pc", instr_pc, 32'h102);
    check("rd_tgt_comp", instr_compressed, 1);

    // ---------------- backpressure ----------------
    mem.delete();
    start_test(4);
    writes = 0;
    for (int k = 1; k <= 10; k++) begin
      to_cycle(k); #1;
      if (buf_write_en) writes++;
      check("bp_hw_bound", 32'(dut.hw_cnt <= 8), 1);
    end
    check("bp_writes", writes, 4);
    check("bp_hw_full", dut.hw_cnt, 8);
    check("bp_req", imem_req, 0);
    check("bp_valid", instr_valid, 1);
    to_cycle(11); instr_ready = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      waitc = 0;
      while (!instr_valid && waitc < 8) begin
        @(negedge clk); #1;
        waitc++;
      end
      check("bp_drain_valid", instr_valid, 1);
      check("bp_drain_pc", instr_pc, 32'(4 * i));
      @(negedge clk); #1;
    end

    // ---------------- reset mid-flight ----------------
    mem.delete();
    delay_addr = 32'h8; delay_cycles = 3;
    start_test(4);
    instr_ready = 1'b1;
    to_cycle(5);
    rst = 1'b1; fetch_en = 1'b0; #1;
    check("mrst_req", imem_req, 0);
    check("mrst_flush", buf_flush, 1);
    check("mrst_valid", instr_valid, 0);
    check("mrst_wen", buf_write_en, 0);
    check("mrst_re", buf_read_en, 0);
    to_cycle(6);
    delay_addr = 32'hFFFF_FFFF; #1;
    check("mrst_pc", instr_pc, 0);
    check("mrst_addr", imem_addr, 0);
    check("mrst_dut_out", dut.outstanding, 0);
    to_cycle(7);
    rst = 1'b0; #1;
    check("mrst_stale0", buf_write_en, 0);
    to_cycle(8); #1;
    check("mrst_stale1", buf_write_en, 0);
    to_cycle(9);
    fetch_en = 1'b1; #1;
    to_cycle(10); #1;
    check("mrst_req_again", imem_req, 1);
    check("mrst_addr_again", imem_addr, 32'h0);
    to_cycle(12); #1;
    check("mrst_valid_again", instr_valid, 1);
    check("mrst_pc_again", instr_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
